// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared PC generator constants: state encoding and default vectors
package pc_pkg;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Also consumed by the exception unit and the linker-script checks.
    localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0040_0004;
    localparam int          PC_STEP      = 4;

endpackage

// File: rtl/pc_trace_buf.sv
// rtl/pc_trace_buf.sv - ring buffer of accepted fetch addresses, newest at read index 0
module pc_trace_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [XLEN-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(DEPTH);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0] rd_ptr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign rd_ptr  = wr_ptr_q - IDX_W'(1) - rd_idx;
    assign rd_data = mem_q[rd_ptr];
    assign count   = cnt_q;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program counter with fetch handshake, redirects, halt; trace via PC_GEN_TRACE_EN
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(PC_EXC_VEC),
    parameter int              STEP       = PC_STEP,
    parameter int              ALIGN_BITS = 2
`ifdef PC_GEN_TRACE_EN
    ,
    parameter int              TRACE_DEPTH = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_req,
    input  logic [XLEN-1:0] br_target,
    input  logic            exc_req,
    input  logic            halt_req,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic            misalign_err,
    output logic            halted
`ifdef PC_GEN_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt
`endif
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic            redirect;
    logic            br_misaligned;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_accept;

    assign fetch_valid  = (state_q == ST_RUN) && !stall;
    assign fetch_accept = fetch_valid && fetch_ready;

    // An exception redirect suppresses the alignment check on a concurrent branch.
    assign redirect      = exc_req || br_req;
    assign br_misaligned = !exc_req && br_req && ((br_target & ALIGN_MASK) != '0);
    assign redirect_pc   = (exc_req || br_misaligned) ? EXC_VEC : br_target;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    misalign_d = br_misaligned;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else if (fetch_accept) begin
                    pc_d = pc_q + STEP_INC;
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    state_d    = ST_RUN;
                    pc_d       = redirect_pc;
                    misalign_d = br_misaligned;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == ST_HALT);

`ifdef PC_GEN_TRACE_EN
    pc_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fetch_accept),
        .wr_data (pc_q),
        .rd_idx  (trace_idx),
        .rd_data (trace_pc),
        .count   (trace_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen: directed scenarios plus randomized traffic
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br_req = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        exc_req = 1'b0;
    logic        halt_req = 1'b0;
    logic        fetch_ready = 1'b1;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        misalign_err;
    logic        halted;
`ifdef PC_GEN_TRACE_EN
    logic [2:0]  trace_idx = 3'd0;
    logic [31:0] trace_pc;
    logic [3:0]  trace_cnt;
`endif

    pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .br_req       (br_req),
        .br_target    (br_target),
        .exc_req      (exc_req),
        .halt_req     (halt_req),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .misalign_err (misalign_err),
        .halted       (halted)
`ifdef PC_GEN_TRACE_EN
        ,
        .trace_idx    (trace_idx),
        .trace_pc     (trace_pc),
        .trace_cnt    (trace_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode, pc and the history of accepted fetch addresses.
    typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;
    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        mis;
        logic        halted;
    } exp_t;

    mode_t       m_mode = M_BOOT;
    logic [31:0] m_pc = RV;
    exp_t        sb_q[$];
    logic [31:0] hist[$];

    always @(posedge clk) begin
        mode_t       nm;
        logic [31:0] np;
        logic        mis;
        exp_t        e;
        if (rst_n) begin
            nm  = m_mode;
            np  = m_pc;
            mis = 1'b0;
            if (m_mode == M_BOOT) begin
                nm = M_RUN;
            end else if (exc_req) begin
                np = EV;
                nm = M_RUN;
            end else if (br_req) begin
                nm = M_RUN;
                if (br_target % 4 != 0) begin
                    np  = EV;
                    mis = 1'b1;
                end else begin
                    np = br_target;
                end
            end else if (m_mode == M_RUN) begin
                if (halt_req) begin
                    nm = M_HALT;
                end else if (!stall && fetch_ready) begin
                    hist.push_front(m_pc);
                    if (hist.size() > 8) void'(hist.pop_back());
                    np = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                end
            end
            e.pc     = np;
            e.fv     = (nm == M_RUN) && !stall;
            e.mis    = mis;
            e.halted = (nm == M_HALT);
            sb_q.push_back(e);
            m_mode <= nm;
            m_pc   <= np;
        end
    end

    always @(negedge rst_n) begin
        m_mode <= M_BOOT;
        m_pc   <= RV;
        sb_q.delete();
        hist.delete();
    end

    // Monitor: one expected entry per clock edge while out of reset.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_fetch_valid", 32'(fetch_valid), 32'(e.fv));
            chk("sb_misalign_err", 32'(misalign_err), 32'(e.mis));
            chk("sb_halted", 32'(halted), 32'(e.halted));
        end
    end

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic ex, input logic hl, input logic rdy);
        stall       = st;
        br_req      = br;
        br_target   = tgt;
        exc_req     = ex;
        halt_req    = hl;
        fetch_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_pc", pc, RV);
        chk("reset_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("reset_misalign", 32'(misalign_err), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("boot_fetch_valid", 32'(fetch_valid), 32'd0);

        idle(1'b1);
        chk("run_pc0", pc, 32'h0040_0000);
        chk("run_fv0", 32'(fetch_valid), 32'd1);
        idle(1'b1);
        chk("run_pc1", pc, 32'h0040_0004);
        idle(1'b1);
        chk("run_pc2", pc, 32'h0040_0008);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("not_ready_pc", pc, 32'h0040_0008);
            chk("not_ready_fv", 32'(fetch_valid), 32'd1);
        end
        idle(1'b1);
        chk("ready_again_pc", pc, 32'h0040_000C);

        drive(1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b1);
        chk("stall_br_pc", pc, 32'h0040_0100);
        chk("stall_br_fv", 32'(fetch_valid), 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("stall_hold_pc", pc, 32'h0040_0100);

        drive(1'b0, 1'b1, 32'h0040_0102, 1'b0, 1'b0, 1'b1);
        chk("misalign_pc", pc, EV);
        chk("misalign_flag", 32'(misalign_err), 32'd1);
        idle(1'b1);
        chk("misalign_pulse_end", 32'(misalign_err), 32'd0);
        drive(1'b0, 1'b1, 32'h0040_0102, 1'b1, 1'b0, 1'b1);
        chk("exc_br_pc", pc, EV);
        chk("exc_br_misalign", 32'(misalign_err), 32'd0);

        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_fv", 32'(fetch_valid), 32'd0);
            chk("halt_pc", pc, EV);
            idle(1'b1);
        end
        drive(1'b0, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 1'b1);
        chk("unhalt_pc", pc, 32'h0040_0200);
        chk("unhalt_flag", 32'(halted), 32'd0);

        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        idle(1'b1);
        chk("wrap_pc", pc, 32'h0000_0000);

`ifdef PC_GEN_TRACE_EN
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("trace_cnt_sat", 32'(trace_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            trace_idx = 3'(i);
            #1;
            chk("trace_entry", trace_pc, 32'h24 - 32'(4 * i));
        end
        trace_idx = 3'd0;
`endif

        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, tgt,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                  $urandom_range(0, 3) != 0);
`ifdef PC_GEN_TRACE_EN
            trace_idx = 3'($urandom_range(0, 7));
            #1;
            chk("rand_trace_cnt", 32'(trace_cnt), 32'(hist.size()));
            if (int'(trace_idx) < hist.size()) chk("rand_trace_pc", trace_pc, hist[int'(trace_idx)]);
`endif
        end

        drive(1'b0, 1'b1, 32'h0040_1000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", pc, RV);
        chk("async_reset_fv", 32'(fetch_valid), 32'd0);
        chk("async_reset_halted", 32'(halted), 32'd0);
`ifdef PC_GEN_TRACE_EN
        chk("async_reset_trace_cnt", 32'(trace_cnt), 32'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("post_reset_pc", pc, 32'h0040_000C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
